// File: rtl/xbar_bank_sched.sv
// Channel-to-bank request scheduler for the HTU/WBUF crossbar.
// Each bank runs its own round-robin arbiter and has one registered slot. Each channel's outstanding requests are capped by a credit counter.
module xbar_bank_sched #(
   parameter int NUM_CH   = 3,
   parameter int NUM_BANK = 4,
   parameter int DATA_W   = 64,
   parameter int MAX_OUT  = 4,
   localparam int BANK_W  = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          ch_req_valid,
   output logic [NUM_CH-1:0]          ch_req_ready,
   input  logic [NUM_CH*BANK_W-1:0]   ch_req_bank,
   input  logic [NUM_CH*DATA_W-1:0]   ch_req_data,
   input  logic [NUM_CH-1:0]          ch_rsp_done,
   output logic [NUM_CH*CNT_W-1:0]    ch_outstanding,
   output logic [NUM_BANK-1:0]        bank_req_valid,
   input  logic [NUM_BANK-1:0]        bank_req_ready,
   output logic [NUM_BANK*DATA_W-1:0] bank_req_data,
   output logic [NUM_BANK*CH_W-1:0]   bank_req_src,
   output logic                       err_underflow
);

   logic [CNT_W-1:0]  cnt [NUM_CH];
   logic [CH_W-1:0]   rr_ptr [NUM_BANK];
   logic [NUM_BANK-1:0] slot_vld;
   logic [DATA_W-1:0] slot_data [NUM_BANK];
   logic [CH_W-1:0]   slot_src [NUM_BANK];

   logic [DATA_W-1:0] ch_data [NUM_CH];
   logic [BANK_W-1:0] ch_bank [NUM_CH];
   logic [NUM_CH-1:0] elig [NUM_BANK];
   logic [NUM_BANK-1:0] load;
   logic [NUM_BANK-1:0] gnt_any;
   logic [CH_W-1:0]   win [NUM_BANK];
   logic [NUM_CH-1:0] accept;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         ch_data[c] = ch_req_data[c*DATA_W +: DATA_W];
         ch_bank[c] = ch_req_bank[c*BANK_W +: BANK_W];
      end
      for (int b = 0; b < NUM_BANK; b++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            elig[b][c] = ch_req_valid[c] && (ch_bank[c] == BANK_W'(b)) &&
                         (cnt[c] < CNT_W'(MAX_OUT));
         end
      end
   end

   // Scan channels starting at rr_ptr and wrap around; the first eligible channel wins.
   always_comb begin
      logic [CH_W:0]   sum;
      logic [CH_W-1:0] idx;
      sum     = '0;
      idx     = '0;
      accept  = '0;
      gnt_any = '0;
      for (int b = 0; b < NUM_BANK; b++) begin
         load[b] = !slot_vld[b] || bank_req_ready[b];
         win[b]  = '0;
         for (int i = 0; i < NUM_CH; i++) begin
            sum = {1'b0, rr_ptr[b]} + (CH_W+1)'(i);
            if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
            idx = sum[CH_W-1:0];
            if (load[b] && !gnt_any[b] && elig[b][idx]) begin
               gnt_any[b]  = 1'b1;
               win[b]      = idx;
               accept[idx] = 1'b1;
            end
         end
      end
   end

   assign ch_req_ready = accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_vld <= '0;
         for (int b = 0; b < NUM_BANK; b++) begin
            slot_data[b] <= '0;
            slot_src[b]  <= '0;
            rr_ptr[b]    <= '0;
         end
      end else begin
         for (int b = 0; b < NUM_BANK; b++) begin
            if (load[b]) begin
               slot_vld[b] <= gnt_any[b];
               if (gnt_any[b]) begin
                  slot_data[b] <= ch_data[win[b]];
                  slot_src[b]  <= win[b];
                  rr_ptr[b]    <= (win[b] == CH_W'(NUM_CH-1)) ? '0 : win[b] + 1'b1;
               end
            end
         end
      end
   end

   // Accept and done in the same cycle cancel out. A done that arrives at zero is flagged and otherwise ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_underflow <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (accept[c] && !ch_rsp_done[c]) begin
               cnt[c] <= cnt[c] + 1'b1;
            end else if (!accept[c] && ch_rsp_done[c]) begin
               if (cnt[c] == '0) err_underflow <= 1'b1;
               else              cnt[c] <= cnt[c] - 1'b1;
            end
         end
      end
   end

   always_comb begin
      bank_req_valid = slot_vld;
      for (int b = 0; b < NUM_BANK; b++) begin
         bank_req_data[b*DATA_W +: DATA_W] = slot_data[b];
         bank_req_src[b*CH_W +: CH_W]      = slot_src[b];
      end
      for (int c = 0; c < NUM_CH; c++) ch_outstanding[c*CNT_W +: CNT_W] = cnt[c];
   end

   // Upstream must hold a pending request steady until it is accepted.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_chk
      a_hold: assert property (@(posedge clk) disable iff (rst)
         (ch_req_valid[c] && !ch_req_ready[c]) |=>
            (ch_req_valid[c] && $stable(ch_req_bank[c*BANK_W +: BANK_W]) &&
             $stable(ch_req_data[c*DATA_W +: DATA_W])));
      a_rdy: assert property (@(posedge clk) ch_req_ready[c] |-> ch_req_valid[c]);
   end

endmodule

// File: tb/tb_xbar_bank_sched.sv
// Directed bench for xbar_bank_sched: a queue-free reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_xbar_bank_sched;
   localparam int NUM_CH = 3, NUM_BANK = 4, DATA_W = 64, MAX_OUT = 4;
   localparam int BANK_W = 2, CH_W = 2, CNT_W = 3;

   logic                       clk = 1'b0;
   logic                       rst;
   logic [NUM_CH-1:0]          ch_req_valid;
   logic [NUM_CH-1:0]          ch_req_ready;
   logic [NUM_CH*BANK_W-1:0]   ch_req_bank;
   logic [NUM_CH*DATA_W-1:0]   ch_req_data;
   logic [NUM_CH-1:0]          ch_rsp_done;
   logic [NUM_CH*CNT_W-1:0]    ch_outstanding;
   logic [NUM_BANK-1:0]        bank_req_valid;
   logic [NUM_BANK-1:0]        bank_req_ready;
   logic [NUM_BANK*DATA_W-1:0] bank_req_data;
   logic [NUM_BANK*CH_W-1:0]   bank_req_src;
   logic                       err_underflow;

   always #5 clk = ~clk;

   xbar_bank_sched #(.NUM_CH(NUM_CH), .NUM_BANK(NUM_BANK), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .rst(rst),
      .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
      .ch_req_bank(ch_req_bank), .ch_req_data(ch_req_data),
      .ch_rsp_done(ch_rsp_done), .ch_outstanding(ch_outstanding),
      .bank_req_valid(bank_req_valid), .bank_req_ready(bank_req_ready),
      .bank_req_data(bank_req_data), .bank_req_src(bank_req_src),
      .err_underflow(err_underflow)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the state that the rules imply.
   int               m_cnt [NUM_CH];
   int               m_rr  [NUM_BANK];
   bit               m_vld [NUM_BANK];
   logic [DATA_W-1:0] m_data [NUM_BANK];
   int               m_src [NUM_BANK];
   bit               m_err;

   function automatic int m_winner(int b);
      if (m_vld[b] && !bank_req_ready[b]) return -1;
      for (int i = 0; i < NUM_CH; i++) begin
         int c;
         c = (m_rr[b] + i) % NUM_CH;
         if (ch_req_valid[c] && (int'(ch_req_bank[c*BANK_W +: BANK_W]) == b) && m_cnt[c] < MAX_OUT)
            return c;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      int w [NUM_BANK];
      bit acc [NUM_CH];
      if (rst) begin
         for (int b = 0; b < NUM_BANK; b++) begin
            m_rr[b] = 0; m_vld[b] = 0; m_data[b] = '0; m_src[b] = 0;
         end
         for (int c = 0; c < NUM_CH; c++) m_cnt[c] = 0;
         m_err = 0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) acc[c] = 0;
         for (int b = 0; b < NUM_BANK; b++) begin
            w[b] = m_winner(b);
            if (w[b] >= 0) acc[w[b]] = 1;
         end
         for (int b = 0; b < NUM_BANK; b++) begin
            if (!m_vld[b] || bank_req_ready[b]) begin
               if (w[b] >= 0) begin
                  m_vld[b]  = 1;
                  m_data[b] = ch_req_data[w[b]*DATA_W +: DATA_W];
                  m_src[b]  = w[b];
                  m_rr[b]   = (w[b] + 1) % NUM_CH;
               end else begin
                  m_vld[b] = 0;
               end
            end
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (acc[c] && !ch_rsp_done[c]) m_cnt[c]++;
            else if (!acc[c] && ch_rsp_done[c]) begin
               if (m_cnt[c] == 0) m_err = 1;
               else m_cnt[c]--;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [NUM_CH-1:0]   er;
      logic [NUM_BANK-1:0] ev;
      int w;
      if (chk_en) begin
         er = '0;
         ev = '0;
         for (int b = 0; b < NUM_BANK; b++) begin
            w = m_winner(b);
            if (w >= 0) er[w] = 1'b1;
            ev[b] = m_vld[b];
         end
         chk("ready", 64'(ch_req_ready), 64'(er));
         chk("bank_valid", 64'(bank_req_valid), 64'(ev));
         for (int b = 0; b < NUM_BANK; b++) begin
            if (m_vld[b]) begin
               chk("slot_data", bank_req_data[b*DATA_W +: DATA_W], m_data[b]);
               chk("slot_src", 64'(bank_req_src[b*CH_W +: CH_W]), 64'(m_src[b]));
            end
         end
         for (int c = 0; c < NUM_CH; c++)
            chk("cnt", 64'(ch_outstanding[c*CNT_W +: CNT_W]), 64'(m_cnt[c]));
         chk("err", 64'(err_underflow), 64'(m_err));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      ch_req_valid   = '0;
      ch_rsp_done    = '0;
      bank_req_ready = '1;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic set_req(input int c, input int b, input logic [63:0] d);
      ch_req_valid[c] = 1'b1;
      ch_req_bank[c*BANK_W +: BANK_W] = BANK_W'(b);
      ch_req_data[c*DATA_W +: DATA_W] = d;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int seq [6];
      int ngr [NUM_CH];
      seq = '{0, 1, 2, 0, 1, 2};
      ch_req_bank = '0;
      ch_req_data = '0;
      do_reset();
      chk_en = 1;
      chk("rst_valid", 64'(bank_req_valid), 64'h0);
      chk("rst_cnt", 64'(ch_outstanding), 64'h0);
      chk("rst_err", 64'(err_underflow), 64'h0);

      // 1: single request ch0 -> bank2
      set_req(0, 2, 64'hA5);
      #1 chk("t1_ready", 64'(ch_req_ready), 64'h1);
      tick();
      ch_req_valid = '0;
      chk("t1_valid", 64'(bank_req_valid), 64'h4);
      chk("t1_data", bank_req_data[2*DATA_W +: DATA_W], 64'hA5);
      chk("t1_src", 64'(bank_req_src[5:4]), 64'h0);
      chk("t1_cnt0", 64'(ch_outstanding[2:0]), 64'h1);

      // 2: three channels contend for bank1, two requests each
      do_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         set_req(c, 1, 64'h100 + 64'(c));
         ngr[c] = 0;
      end
      for (int k = 0; k < 6; k++) begin
         #1 chk("t2_grant", 64'(ch_req_ready), 64'h1 << seq[k]);
         tick();
         ngr[seq[k]]++;
         if (ngr[seq[k]] == 2) ch_req_valid[seq[k]] = 1'b0;
         chk("t2_valid", 64'(bank_req_valid[1]), 64'h1);
         chk("t2_src", 64'(bank_req_src[3:2]), 64'(seq[k]));
      end
      tick();
      chk("t2_drain", 64'(bank_req_valid), 64'h0);

      // 3: backpressure on bank3
      do_reset();
      bank_req_ready[3] = 1'b0;
      set_req(0, 3, 64'h30);
      #1 chk("t3_fill", 64'(ch_req_ready), 64'h1);
      tick();
      ch_req_valid[0] = 1'b0;
      set_req(1, 3, 64'h31);
      for (int k = 0; k < 3; k++) begin
         #1 chk("t3_blocked", 64'(ch_req_ready), 64'h0);
         chk("t3_hold_data", bank_req_data[3*DATA_W +: DATA_W], 64'h30);
         chk("t3_hold_src", 64'(bank_req_src[7:6]), 64'h0);
         tick();
      end
      bank_req_ready[3] = 1'b1;
      #1 chk("t3_ready", 64'(ch_req_ready), 64'h2);
      tick();
      ch_req_valid[1] = 1'b0;
      chk("t3_b2b_valid", 64'(bank_req_valid[3]), 64'h1);
      chk("t3_b2b_data", bank_req_data[3*DATA_W +: DATA_W], 64'h31);
      chk("t3_b2b_src", 64'(bank_req_src[7:6]), 64'h1);
      tick();
      chk("t3_empty", 64'(bank_req_valid[3]), 64'h0);

      // 4: credit limit on ch2
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_req(2, 0, 64'h40 + 64'(i));
         #1 chk("t4_accept", 64'(ch_req_ready), 64'h4);
         tick();
      end
      set_req(2, 0, 64'h44);
      #1 chk("t4_blocked", 64'(ch_req_ready), 64'h0);
      chk("t4_cnt4", 64'(ch_outstanding[8:6]), 64'h4);
      ch_rsp_done[2] = 1'b1;
      #1 chk("t4_done_blocked", 64'(ch_req_ready), 64'h0);
      tick();
      ch_rsp_done[2] = 1'b0;
      chk("t4_cnt3", 64'(ch_outstanding[8:6]), 64'h3);
      #1 chk("t4_fifth", 64'(ch_req_ready), 64'h4);
      tick();
      chk("t4_cnt4b", 64'(ch_outstanding[8:6]), 64'h4);
      set_req(2, 0, 64'h45);
      ch_rsp_done[2] = 1'b1;
      tick();
      chk("t4_cnt3b", 64'(ch_outstanding[8:6]), 64'h3);
      #1 chk("t4_both", 64'(ch_req_ready), 64'h4);
      tick();
      ch_rsp_done[2] = 1'b0;
      ch_req_valid = '0;
      chk("t4_cnt_kept", 64'(ch_outstanding[8:6]), 64'h3);

      // 5: underflow is sticky until reset, reset drops slots
      do_reset();
      bank_req_ready[1] = 1'b0;
      set_req(1, 1, 64'h51);
      tick();
      ch_req_valid = '0;
      ch_rsp_done[0] = 1'b1;
      tick();
      ch_rsp_done[0] = 1'b0;
      chk("t5_err", 64'(err_underflow), 64'h1);
      chk("t5_cnt0", 64'(ch_outstanding[2:0]), 64'h0);
      tick();
      tick();
      chk("t5_sticky", 64'(err_underflow), 64'h1);
      chk("t5_slot_held", 64'(bank_req_valid), 64'h2);
      do_reset();
      chk("t5_rst_err", 64'(err_underflow), 64'h0);
      chk("t5_rst_slots", 64'(bank_req_valid), 64'h0);
      chk("t5_rst_cnt", 64'(ch_outstanding), 64'h0);

      // 6: three banks granted in parallel
      do_reset();
      set_req(0, 0, 64'h60);
      set_req(1, 1, 64'h61);
      set_req(2, 2, 64'h62);
      #1 chk("t6_ready", 64'(ch_req_ready), 64'h7);
      tick();
      ch_req_valid = '0;
      chk("t6_valid", 64'(bank_req_valid), 64'h7);
      chk("t6_d0", bank_req_data[0 +: DATA_W], 64'h60);
      chk("t6_d1", bank_req_data[DATA_W +: DATA_W], 64'h61);
      chk("t6_d2", bank_req_data[2*DATA_W +: DATA_W], 64'h62);
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
